mem_ack_responder: RTL and testbench

MEM_ACK_RESPONDER -- requirements
Module: mem_ack_responder

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/mem_resp_ram.sv | 49 ++++
 rtl/mem_ack_responder.sv | 126 ++++++++++++
 tb/tb_mem_ack_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared state encoding and default sizing for the wait-stated memory responder.
package mem_resp_pkg;

    localparam int unsigned DefAw   = 6;
    localparam int unsigned DefDw   = 32;
    localparam int unsigned DefWait = 2;
    localparam int unsigned CntW    = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLatency = 2'd1,
        StAck     = 2'd2,
        StRelease = 2'd3
    } state_e;

endpackage

// File: rtl/mem_resp_ram.sv
// Synchronous single-port RAM with registered read; contents survive reset.
// Optional per-byte write enables when MEM_RESP_BE_EN is defined.
module mem_resp_ram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
`ifdef MEM_RESP_BE_EN
    input  logic [DW/8-1:0] be_i,
`endif
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem_q [Depth];
    logic [DW-1:0] rdata_q;

`ifdef MEM_RESP_BE_EN
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(DW / 8); b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
`endif

    // Only the read register is reset; the array itself keeps its contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ack_responder.sv
// Memory responder: inserts WAIT wait states, then pulses active-low ACK_N for one cycle.
// Define MEM_RESP_BE_EN to add the BE byte-enable port.
module mem_ack_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW   = DefAw,
    parameter int unsigned DW   = DefDw,
    parameter int unsigned WAIT = DefWait
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          MR,
    input  logic          MW,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DIN,
`ifdef MEM_RESP_BE_EN
    input  logic [DW/8-1:0] BE,
`endif
    output logic [DW-1:0] DOUT,
    output logic          ACK_N,
    output logic [1:0]    STATE
);

    localparam logic [CntW-1:0] WaitInit = (WAIT == 0) ? '0 : CntW'(WAIT - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic            wr_q;
    logic            ack_n_q;
`ifdef MEM_RESP_BE_EN
    logic [DW/8-1:0] be_q;
    logic [DW/8-1:0] ram_be;
`endif

    logic          req;
    logic          idle;
    logic          fire;
    logic          op_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    assign req  = MR | MW;
    assign idle = (state_q == StIdle);

    // With WAIT=0 the access fires on the accepting edge, so live inputs feed the RAM.
    assign fire = (idle && req && (WAIT == 0)) ||
                  ((state_q == StLatency) && req && (cnt_q == '0));
    assign op_wr     = idle ? MW : wr_q;
    assign ram_addr  = idle ? ADDR : addr_q;
    assign ram_wdata = idle ? DIN : din_q;
`ifdef MEM_RESP_BE_EN
    assign ram_be    = idle ? BE : be_q;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            ack_n_q <= 1'b1;
`ifdef MEM_RESP_BE_EN
            be_q    <= '0;
`endif
        end else begin
            ack_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q <= ADDR;
                        din_q  <= DIN;
                        wr_q   <= MW;
`ifdef MEM_RESP_BE_EN
                        be_q   <= BE;
`endif
                        if (WAIT == 0) begin
                            state_q <= StAck;
                            ack_n_q <= 1'b0;
                        end else begin
                            state_q <= StLatency;
                            cnt_q   <= WaitInit;
                        end
                    end
                end
                StLatency: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        state_q <= StAck;
                        ack_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StAck: state_q <= StRelease;
                StRelease: begin
                    if (!req) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mem_resp_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (fire && op_wr),
        .re_i    (fire && !op_wr),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
`ifdef MEM_RESP_BE_EN
        .be_i    (ram_be),
`endif
        .rdata_o (DOUT)
    );

    assign ACK_N = ack_n_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_mem_ack_responder.sv
// Directed bench for mem_ack_responder: WAIT=2 and WAIT=0 instances, read-data scoreboard.
module tb_mem_ack_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr = 1'b0, mw = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = 4'hF;
    logic [31:0] dout;
    logic        ack_n;
    logic [1:0]  state;

    logic        mr0 = 1'b0, mw0 = 1'b0;
    logic [5:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic [3:0]  be0 = 4'hF;
    logic [31:0] dout0;
    logic        ack_n0;
    logic [1:0]  state0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_ack_responder #(.AW(6), .DW(32), .WAIT(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .MR    (mr),
        .MW    (mw),
        .ADDR  (addr),
        .DIN   (din),
`ifdef MEM_RESP_BE_EN
        .BE    (be),
`endif
        .DOUT  (dout),
        .ACK_N (ack_n),
        .STATE (state)
    );

    mem_ack_responder #(.AW(6), .DW(32), .WAIT(0)) dut0 (
        .CLK   (clk),
        .RESET (rst),
        .MR    (mr0),
        .MW    (mw0),
        .ADDR  (addr0),
        .DIN   (din0),
`ifdef MEM_RESP_BE_EN
        .BE    (be0),
`endif
        .DOUT  (dout0),
        .ACK_N (ack_n0),
        .STATE (state0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
`ifdef MEM_RESP_BE_EN
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
`else
        r = d;
        if (b == 4'hx) r = old;
`endif
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where IDLE is seen again.
    task automatic access(input bit wr, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] b, input int hold);
        int lows;
        int first;
        mr = !wr; mw = wr; addr = a; din = d; be = b;
        if (wr) model[a] = merge(model[a], d, b);
        else exp_q.push_back(model[a]);
        lows = 0;
        first = 0;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (ack_n === 1'b0) begin
                lows++;
                if (first == 0) first = k;
                if (!wr) begin
                    if (exp_q.size() > 0) check("rdata", dout, exp_q.pop_front());
                    else check("rdata_unexpected", 32'd1, 32'd0);
                end
            end
            // Scramble inputs after acceptance; the latched copies must be used.
            if (k == 1) begin addr = ~a; din = ~d; be = ~b; end
        end
        check("ack_latency", first, 3);
        check("ack_pulses", lows, 1);
        check("release_hold", state, 2'd3);
        mr = 1'b0; mw = 1'b0;
        @(negedge clk);
        check("back_to_idle", state, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        repeat (2) @(negedge clk);
        check("rst_ack_n", ack_n, 1'b1);
        check("rst_state", state, 2'd0);
        check("rst_dout", dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write/readback with WAIT=2, then back-to-back traffic.
        access(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 5);
        access(0, 6'd5, 32'h0, 4'hF, 5);
        access(1'b1, 6'd7, 32'h12345678, 4'hF, 5);
        access(1'b1, 6'd12, 32'hA5A55A5A, 4'hF, 13);
        access(0, 6'd12, 32'h0, 4'hF, 5);
        access(0, 6'd7, 32'h0, 4'hF, 4);

        // Request dropped during LATENCY: no ACK, no write.
        mw = 1'b1; addr = 6'd7; din = 32'h1;
        @(negedge clk);
        check("abort_in_latency", state, 2'd1);
        mw = 1'b0;
        lows = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack_n === 1'b0) lows++;
        end
        check("abort_no_ack", lows, 0);
        check("abort_idle", state, 2'd0);
        access(0, 6'd7, 32'h0, 4'hF, 4);

        // Async reset mid-LATENCY discards the pending write.
        access(1'b1, 6'd3, 32'hCAFEF00D, 4'hF, 4);
        access(0, 6'd3, 32'h0, 4'hF, 4);
        mw = 1'b1; addr = 6'd3; din = 32'h0BADBEEF;
        @(negedge clk);
        check("pre_reset_state", state, 2'd1);
        #1 rst = 1'b1; mw = 1'b0;
        #1;
        check("async_rst_state", state, 2'd0);
        check("async_rst_ack_n", ack_n, 1'b1);
        check("async_rst_dout", dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(0, 6'd3, 32'h0, 4'hF, 4);

`ifdef MEM_RESP_BE_EN
        access(1'b1, 6'd2, 32'h11223344, 4'hF, 4);
        access(1'b1, 6'd2, 32'hAABBCCDD, 4'b0101, 4);
        check("be_model", model[2], 32'h11BB33DD);
        access(0, 6'd2, 32'h0, 4'hF, 4);
        access(1'b1, 6'd2, 32'hFFFFFFFF, 4'b0000, 4);
        access(0, 6'd2, 32'h0, 4'hF, 4);
`endif

        // WAIT=0 instance: ACK in the cycle right after accept, states 0,2,3,0.
        check("w0_idle", state0, 2'd0);
        mw0 = 1'b1; addr0 = 6'd9; din0 = 32'h5A5A0001;
        @(negedge clk);
        check("w0_wr_state_ack", state0, 2'd2);
        check("w0_wr_ack_n", ack_n0, 1'b0);
        @(negedge clk);
        check("w0_wr_release", state0, 2'd3);
        mw0 = 1'b0;
        @(negedge clk);
        check("w0_wr_idle", state0, 2'd0);
        mr0 = 1'b1; addr0 = 6'd9;
        exp_q.push_back(32'h5A5A0001);
        @(negedge clk);
        check("w0_rd_state_ack", state0, 2'd2);
        check("w0_rd_ack_n", ack_n0, 1'b0);
        if (exp_q.size() > 0) check("w0_rdata", dout0, exp_q.pop_front());
        @(negedge clk);
        check("w0_rd_release", state0, 2'd3);
        check("w0_rd_ack_high", ack_n0, 1'b1);
        mr0 = 1'b0;
        @(negedge clk);
        check("w0_rd_idle", state0, 2'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
